// File: rtl/multi_cycle_control_pkg.sv
// Shared constants for the multi-cycle controller: opcodes, FSM states and
// immediate-generator select codes.
package multi_cycle_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'b000,
        IMM_I    = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_U    = 3'b100,
        IMM_J    = 3'b101
    } imm_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic opcode_supported(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Unsupported opcodes map to IMM_NONE, same as register-register OP.
    function automatic imm_t imm_of(input logic [6:0] opcode);
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_ctrl_decode.sv
// Combinational control decode: datapath strobes from the current state,
// the latched opcode and the two qualifying inputs.
import multi_cycle_control_pkg::*;

module ctrl_decode (
    input  state_t      state,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic [2:0]  imm_type,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal
);

    logic is_store;
    logic is_branch;
    logic is_jump;

    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        imm_type  = IMM_NONE;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            S_DECODE: begin
                imm_type = imm_of(opcode);
            end
            S_EXECUTE: begin
                imm_type  = imm_of(opcode);
                alu_src_a = (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || is_branch;
                alu_src_b = (opcode != OPC_OP);
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken;
                end
            end
            S_MEM: begin
                imm_type = imm_of(opcode);
                mem_req  = 1'b1;
                mem_we   = is_store;
                // A store retires in its mem_ready cycle; PC+4 is the only option.
                pc_write = is_store && mem_ready;
            end
            S_WRITEBACK: begin
                imm_type  = imm_of(opcode);
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = is_jump;
                if (opcode == OPC_LOAD) wb_sel = 2'b01;
                else if (is_jump)       wb_sel = 2'b10;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle instruction sequencer: state register, latched opcode and
// next-state logic; output decode lives in ctrl_decode.
import multi_cycle_control_pkg::*;

module multi_cycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_rdata,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic [2:0]  imm_type,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal
);

    state_t     state;
    logic [6:0] opcode;

    // Only the opcode field steers sequencing; the rest belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_rdata[31:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            opcode <= 7'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        opcode <= instr_rdata[6:0];
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: state <= opcode_supported(opcode) ? S_EXECUTE : S_TRAP;
                S_EXECUTE: begin
                    if (opcode == OPC_LOAD || opcode == OPC_STORE) state <= S_MEM;
                    else if (opcode == OPC_BRANCH)                 state <= S_FETCH;
                    else                                           state <= S_WRITEBACK;
                end
                S_MEM: begin
                    if (mem_ready) state <= (opcode == OPC_LOAD) ? S_WRITEBACK : S_FETCH;
                end
                S_WRITEBACK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_IDLE;
            endcase
        end
    end

    ctrl_decode u_ctrl_decode (
        .state        (state),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .imm_type     (imm_type),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .illegal      (illegal)
    );

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: every cycle the full output vector is
// compared against a per-instruction phase model.
module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_rdata;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req, mem_we, ir_write, alu_src_a, alu_src_b;
    logic        reg_write, pc_write, pc_src, illegal;
    logic [2:0]  imm_type;
    logic [1:0]  wb_sel;
    logic [13:0] outs;

    int checks = 0;
    int errors = 0;

    localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_BAD = 4;

    multi_cycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .instr_rdata  (instr_rdata),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .imm_type     (imm_type),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    assign outs = {mem_req, mem_we, ir_write, imm_type, alu_src_a, alu_src_b,
                   reg_write, wb_sel, pc_write, pc_src, illegal};

    function automatic logic [13:0] mk(input logic mreq, input logic mwe, input logic irw,
                                       input logic [2:0] imm, input logic sa, input logic sb,
                                       input logic rw, input logic [1:0] wb, input logic pw,
                                       input logic ps, input logic ill);
        return {mreq, mwe, irw, imm, sa, sb, rw, wb, pw, ps, ill};
    endfunction

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0010011, 7'b0110011: return C_ALU;
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: return 3'b001;
            7'b0100011:                         return 3'b010;
            7'b1100011:                         return 3'b011;
            7'b0110111, 7'b0010111:             return 3'b100;
            7'b1101111:                         return 3'b101;
            default:                            return 3'b000;
        endcase
    endfunction

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    task automatic step(input string tag, input logic [13:0] exp);
        @(negedge clk);
        checks++;
        assert (outs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic mr);
        rst = 1'b1;
        mem_ready = mr;
        @(posedge clk);
        #1;
        mem_ready = rbit();
        step("rst_hold", 14'd0);
        rst = 1'b0;
        mem_ready = rbit();
        step("idle", 14'd0);
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic taken,
                             input int fstall, input int mstall, input bit stop_in_mem);
        logic [6:0] op;
        int         c;
        logic [2:0] imm;
        logic       sa, sb, st, ps;
        logic [1:0] wb;
        op  = instr[6:0];
        c   = cls_of(op);
        imm = exp_imm(op);
        sa  = (op == 7'b0010111) || (op == 7'b1101111) || (op == 7'b1100011);
        sb  = (op != 7'b0110011);
        st  = (c == C_ST);
        ps  = (op == 7'b1101111) || (op == 7'b1100111);
        wb  = (c == C_LD) ? 2'b01 : (ps ? 2'b10 : 2'b00);

        for (int k = 0; k < fstall; k++) begin
            mem_ready = 1'b0;
            instr_rdata = $urandom;
            branch_taken = rbit();
            step("fetch_wait", mk(1, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        mem_ready = 1'b1;
        instr_rdata = instr;
        step("fetch", mk(1, 0, 1, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0));

        mem_ready = rbit();
        instr_rdata = $urandom;
        step("decode", mk(0, 0, 0, imm, 0, 0, 0, 2'b00, 0, 0, 0));
        if (c == C_BAD) begin
            for (int k = 0; k < 4; k++) begin
                mem_ready = rbit();
                step("trap", mk(0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 1));
            end
            return;
        end

        mem_ready = rbit();
        branch_taken = (c == C_BR) ? taken : rbit();
        step("execute", mk(0, 0, 0, imm, sa, sb, 0, 2'b00, c == C_BR, (c == C_BR) && taken, 0));
        if (c == C_BR) return;

        if (c == C_LD || c == C_ST) begin
            for (int k = 0; k < mstall; k++) begin
                mem_ready = 1'b0;
                step("mem_wait", mk(1, st, 0, imm, 0, 0, 0, 2'b00, 0, 0, 0));
            end
            if (stop_in_mem) return;
            mem_ready = 1'b1;
            step("mem", mk(1, st, 0, imm, 0, 0, 0, 2'b00, st, 0, 0));
            if (st) return;
        end

        mem_ready = rbit();
        step("writeback", mk(0, 0, 0, imm, 0, 0, 1, wb, 1, ps, 0));
    endtask

    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        instr_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        run_instr(32'h00500093, 1'b0, 0, 0, 0);   // ADDI
        run_instr(32'h00208463, 1'b1, 0, 0, 0);   // BEQ taken
        run_instr(32'h0000A103, 1'b0, 0, 3, 0);   // LW, three wait cycles
        run_instr(32'h0000006F, 1'b0, 0, 0, 0);   // JAL
        run_instr(32'h00112023, 1'b0, 1, 1, 0);   // SW
        run_instr(32'h00208463, 1'b0, 2, 0, 0);   // BEQ not taken

        // Reset mid-access, coincident with mem_ready.
        run_instr(32'h0000A103, 1'b0, 0, 2, 1);
        do_reset(1'b1);
        run_instr(32'h00500093, 1'b0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            run_instr({r[31:7], ops[$urandom_range(8, 0)]}, rbit(),
                      $urandom_range(2, 0), $urandom_range(2, 0), 0);
        end

        run_instr(32'hFFFFFFFF, 1'b0, 0, 0, 0);
        do_reset(1'b1);
        run_instr(32'h0000006F, 1'b0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
